// File: rtl/ext_req_arb_if.sv
// Shared external memory port: level requests held until a one-cycle done pulse.
// Handshake: ext_rd_req/ext_wr_req rise with stable addr/data/wen and stay high until the target answers with exactly one ext_rrsp_val (read) or ext_wrsp_val (write) pulse; no other flow control exists.
interface ext_req_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  ext_rd_req;
  logic                  ext_wr_req;
  logic [ADDR_WIDTH-1:0] ext_addr;
  logic [DATA_WIDTH-1:0] ext_wr_dat;
  logic [STRB_WIDTH-1:0] ext_wen;
  logic [DATA_WIDTH-1:0] ext_rrsp_dat;
  logic                  ext_rrsp_val;
  logic                  ext_wrsp_val;

  modport master (
    output ext_rd_req, ext_wr_req, ext_addr, ext_wr_dat, ext_wen,
    input  ext_rrsp_dat, ext_rrsp_val, ext_wrsp_val
  );

  modport slave (
    input  ext_rd_req, ext_wr_req, ext_addr, ext_wr_dat, ext_wen,
    output ext_rrsp_dat, ext_rrsp_val, ext_wrsp_val
  );
endinterface

// File: rtl/ext_req_arb.sv
// Round-robin arbiter sharing one external request port between N_REQ requesters,
// one transaction outstanding, with an optional per-grant timeout that completes with an error.
module ext_req_arb #(
  parameter int N_REQ       = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_rd,
  input  logic [N_REQ-1:0]              req_wr,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdat,
  input  logic [N_REQ*STRB_WIDTH-1:0]   req_wen,
  output logic [DATA_WIDTH-1:0]         rsp_rdat,
  output logic [N_REQ-1:0]              rsp_rval,
  output logic [N_REQ-1:0]              rsp_wval,
  output logic                          rsp_err,
  ext_req_arb_if.master                 ext,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DONE    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       rr_q, rr_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic                  ext_rd_req_q, ext_rd_req_d;
  logic                  ext_wr_req_q, ext_wr_req_d;
  logic [ADDR_WIDTH-1:0] ext_addr_q, ext_addr_d;
  logic [DATA_WIDTH-1:0] ext_wr_dat_q, ext_wr_dat_d;
  logic [STRB_WIDTH-1:0] ext_wen_q, ext_wen_d;
  logic [DATA_WIDTH-1:0] rsp_rdat_q, rsp_rdat_d;
  logic [N_REQ-1:0]      rsp_rval_q, rsp_rval_d;
  logic [N_REQ-1:0]      rsp_wval_q, rsp_wval_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  busy_q, busy_d;

  logic [N_REQ-1:0]      active;
  logic [ID_W-1:0]       pick;
  int                    pick_i;
  logic                  rsp_hit;
  logic                  tmo_hit;

  // First active requester at or after ptr, wrapping.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] act,
                                              input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] sel;
    logic            found;
    int              idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && act[idx]) begin
        sel   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    op_wr_d      = op_wr_q;
    ext_rd_req_d = ext_rd_req_q;
    ext_wr_req_d = ext_wr_req_q;
    ext_addr_d   = ext_addr_q;
    ext_wr_dat_d = ext_wr_dat_q;
    ext_wen_d    = ext_wen_q;
    rsp_rdat_d   = rsp_rdat_q;
    rsp_rval_d   = '0;
    rsp_wval_d   = '0;
    rsp_err_d    = rsp_err_q;

    active  = req_rd | req_wr;
    pick    = rr_pick(active, rr_q);
    pick_i  = int'(pick);
    // Only the response type matching the granted op completes it.
    rsp_hit = op_wr_q ? ext.ext_wrsp_val : ext.ext_rrsp_val;
    tmo_hit = TMO_EN && (cnt_q == TMO_LAST);

    case (state_q)
      ST_IDLE: begin
        if (|active) begin
          grant_d      = pick;
          op_wr_d      = req_wr[pick];
          ext_wr_req_d = req_wr[pick];
          ext_rd_req_d = !req_wr[pick];
          ext_addr_d   = req_addr[pick_i*ADDR_WIDTH +: ADDR_WIDTH];
          ext_wr_dat_d = req_wdat[pick_i*DATA_WIDTH +: DATA_WIDTH];
          ext_wen_d    = req_wen[pick_i*STRB_WIDTH +: STRB_WIDTH];
          cnt_d        = '0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rsp_hit) begin
          ext_rd_req_d        = 1'b0;
          ext_wr_req_d        = 1'b0;
          if (!op_wr_q) rsp_rdat_d = ext.ext_rrsp_dat;
          rsp_err_d           = 1'b0;
          rsp_rval_d[grant_q] = !op_wr_q;
          rsp_wval_d[grant_q] = op_wr_q;
          state_d             = ST_DONE;
        end else if (tmo_hit) begin
          ext_rd_req_d        = 1'b0;
          ext_wr_req_d        = 1'b0;
          rsp_rdat_d          = '0;
          rsp_err_d           = 1'b1;
          rsp_rval_d[grant_q] = !op_wr_q;
          rsp_wval_d[grant_q] = op_wr_q;
          state_d             = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        rr_d    = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        rsp_err_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_q         <= '0;
      grant_q      <= '0;
      cnt_q        <= '0;
      op_wr_q      <= 1'b0;
      ext_rd_req_q <= 1'b0;
      ext_wr_req_q <= 1'b0;
      ext_addr_q   <= '0;
      ext_wr_dat_q <= '0;
      ext_wen_q    <= '0;
      rsp_rdat_q   <= '0;
      rsp_rval_q   <= '0;
      rsp_wval_q   <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      op_wr_q      <= op_wr_d;
      ext_rd_req_q <= ext_rd_req_d;
      ext_wr_req_q <= ext_wr_req_d;
      ext_addr_q   <= ext_addr_d;
      ext_wr_dat_q <= ext_wr_dat_d;
      ext_wen_q    <= ext_wen_d;
      rsp_rdat_q   <= rsp_rdat_d;
      rsp_rval_q   <= rsp_rval_d;
      rsp_wval_q   <= rsp_wval_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign ext.ext_rd_req = ext_rd_req_q;
  assign ext.ext_wr_req = ext_wr_req_q;
  assign ext.ext_addr   = ext_addr_q;
  assign ext.ext_wr_dat = ext_wr_dat_q;
  assign ext.ext_wen    = ext_wen_q;
  assign rsp_rdat       = rsp_rdat_q;
  assign rsp_rval       = rsp_rval_q;
  assign rsp_wval       = rsp_wval_q;
  assign rsp_err        = rsp_err_q;
  assign grant_id       = grant_q;
  assign busy           = busy_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ext_req_arb.sv
// Directed bench for ext_req_arb: a transaction table plus hand-written
// sequences for fairness, simultaneous rd+wr and reset during a grant.
module tb_ext_req_arb;
  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_rd, req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdat;
  logic [N*SW-1:0] req_wen;
  logic [DW-1:0]   rsp_rdat;
  logic [N-1:0]    rsp_rval, rsp_wval;
  logic            rsp_err;
  logic [0:0]      grant_id;
  logic            busy;
  logic [1:0]      dbg_state;

  ext_req_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) ext_bus ();

  ext_req_arb #(
    .N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdat(req_wdat), .req_wen(req_wen),
    .rsp_rdat(rsp_rdat), .rsp_rval(rsp_rval), .rsp_wval(rsp_wval), .rsp_err(rsp_err),
    .ext(ext_bus.master),
    .grant_id(grant_id), .busy(busy), .dbg_state(dbg_state)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  rd, wr;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  e0, e1;
    int          lat;       // 0 = target stays silent
    logic [31:0] rdat;
    int          g;
    bit          is_wr;
    logic [31:0] exp_rdat;
    bit          exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ext(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(ext_bus.ext_rd_req || ext_bus.ext_wr_req) && cyc < 20);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ext_req"}, {ext_bus.ext_rd_req, ext_bus.ext_wr_req}, 0);
    chk({tag, "_ext_addr_dat"}, {ext_bus.ext_addr, ext_bus.ext_wr_dat}, 0);
    chk({tag, "_ext_wen"}, ext_bus.ext_wen, 0);
    chk({tag, "_rsp_rdat"}, rsp_rdat, 0);
    chk({tag, "_rsp_pulses"}, {rsp_rval, rsp_wval, rsp_err}, 0);
    chk({tag, "_grant_busy_state"}, {grant_id, busy, dbg_state}, 0);
  endtask

  function automatic vec_t mk(input logic [1:0] rd, input logic [1:0] wr,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [3:0] e0, input logic [3:0] e1,
                              input int lat, input logic [31:0] rdat, input int g,
                              input bit is_wr, input logic [31:0] exp_rdat, input bit exp_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.e0 = e0; v.e1 = e1; v.lat = lat; v.rdat = rdat; v.g = g;
    v.is_wr = is_wr; v.exp_rdat = exp_rdat; v.exp_err = exp_err;
    return v;
  endfunction

  // Respond to the current grant after lat cycles; leaves the bench in the pulse cycle.
  task automatic respond(input bit is_wr, input int lat, input logic [31:0] rdat);
    for (int i = 0; i < lat; i++) begin
      if (i == 0 && lat >= 2) begin
        if (is_wr) begin
          ext_bus.ext_rrsp_val = 1'b1;
          ext_bus.ext_rrsp_dat = 32'hBAD0BAD0;
        end else begin
          ext_bus.ext_wrsp_val = 1'b1;
        end
      end
      step();
      ext_bus.ext_rrsp_val = 1'b0;
      ext_bus.ext_wrsp_val = 1'b0;
      chk("req_held", {ext_bus.ext_wr_req, ext_bus.ext_rd_req}, is_wr ? 2'b10 : 2'b01);
      chk("no_early_pulse", {rsp_rval, rsp_wval}, 0);
    end
    ext_bus.ext_rrsp_dat = is_wr ? 32'hFEEDFACE : rdat;
    if (is_wr) ext_bus.ext_wrsp_val = 1'b1;
    else       ext_bus.ext_rrsp_val = 1'b1;
    step();
    ext_bus.ext_rrsp_val = 1'b0;
    ext_bus.ext_wrsp_val = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int cyc;
    int hi;
    logic [31:0] ea, ed;
    logic [3:0]  ee;
    logic [1:0]  onehot;
    ea = (v.g == 0) ? v.a0 : v.a1;
    ed = (v.g == 0) ? v.d0 : v.d1;
    ee = (v.g == 0) ? v.e0 : v.e1;
    onehot = (v.g == 0) ? 2'b01 : 2'b10;
    req_rd = v.rd; req_wr = v.wr;
    req_addr = {v.a1, v.a0}; req_wdat = {v.d1, v.d0}; req_wen = {v.e1, v.e0};
    wait_ext(cyc);
    chk("grant_latency", cyc, 1);
    chk("grant_id", grant_id, v.g);
    chk("ext_op", {ext_bus.ext_wr_req, ext_bus.ext_rd_req}, v.is_wr ? 2'b10 : 2'b01);
    chk("ext_addr", ext_bus.ext_addr, ea);
    if (v.is_wr) chk("ext_wr_fields", {ext_bus.ext_wr_dat, 28'h0, ext_bus.ext_wen}, {ed, 28'h0, ee});
    if (v.lat == 0) begin
      hi = 1;
      while (hi < 40) begin
        step();
        if (ext_bus.ext_rd_req || ext_bus.ext_wr_req) hi++;
        else break;
      end
      chk("timeout_len", hi, TMO);
    end else begin
      respond(v.is_wr, v.lat, v.rdat);
    end
    chk("pulse_rval", rsp_rval, v.is_wr ? 2'b00 : onehot);
    chk("pulse_wval", rsp_wval, v.is_wr ? onehot : 2'b00);
    chk("rsp_rdat", rsp_rdat, v.exp_rdat);
    chk("rsp_err", rsp_err, v.exp_err);
    req_rd = '0; req_wr = '0;
    step();
    chk("pulse_one_cycle", {rsp_rval, rsp_wval}, 0);
    chk("release_busy", busy, 1);
    step();
    chk("idle_after", {busy, rsp_err}, 2'b00);
  endtask

  initial begin
    int cyc;
    int exp_g[4];
    req_rd = '0; req_wr = '0; req_addr = '0; req_wdat = '0; req_wen = '0;
    ext_bus.ext_rrsp_dat = '0; ext_bus.ext_rrsp_val = 1'b0; ext_bus.ext_wrsp_val = 1'b0;

    //            rd     wr     a0            a1            d0            d1            e0    e1    lat rdat          g  wr exp_rdat      err
    vecs[0] = mk(2'b01, 2'b00, 32'h10000004, 32'h0,       32'h0,        32'h0,        4'h0, 4'h0, 3, 32'hA5A50001, 0, 0, 32'hA5A50001, 0);
    vecs[1] = mk(2'b00, 2'b10, 32'h0,        32'h10000010, 32'h0,       32'hDEADBEEF, 4'h0, 4'h3, 1, 32'h0,        1, 1, 32'hA5A50001, 0);
    vecs[2] = mk(2'b11, 2'b00, 32'h20,       32'h24,       32'h0,       32'h0,        4'h0, 4'h0, 2, 32'h11112222, 0, 0, 32'h11112222, 0);
    vecs[3] = mk(2'b11, 2'b00, 32'h30,       32'h34,       32'h0,       32'h0,        4'h0, 4'h0, 1, 32'h33334444, 1, 0, 32'h33334444, 0);
    vecs[4] = mk(2'b00, 2'b01, 32'h40,       32'h0,        32'hCAFEF00D, 32'h0,       4'hF, 4'h0, 5, 32'h0,        0, 1, 32'h33334444, 0);
    vecs[5] = mk(2'b01, 2'b00, 32'h50,       32'h0,        32'h0,       32'h0,        4'h0, 4'h0, 0, 32'h0,        0, 0, 32'h0,        1);
    vecs[6] = mk(2'b00, 2'b10, 32'h0,        32'h60,       32'h0,       32'h0BAD0BAD, 4'h0, 4'hC, 2, 32'h0,        1, 1, 32'h0,        0);
    vecs[7] = mk(2'b10, 2'b01, 32'h70,       32'h74,       32'h12345678, 32'h0,       4'hF, 4'h0, 1, 32'h0,        0, 1, 32'h0,        0);
    vecs[8] = mk(2'b11, 2'b00, 32'h80,       32'h84,       32'h0,       32'h0,        4'h0, 4'h0, 1, 32'hFFFF0000, 1, 0, 32'hFFFF0000, 0);
    vecs[9] = mk(2'b00, 2'b10, 32'h0,        32'h90,       32'h0,       32'h55AA55AA, 4'h0, 4'h6, 0, 32'h0,        1, 1, 32'h0,        1);

    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Fairness: both requests held, grants must alternate starting at 0.
    exp_g = '{0, 1, 0, 1};
    req_wr = 2'b01; req_rd = 2'b10;
    req_addr = {32'hB4, 32'hB0}; req_wdat = {32'h0, 32'h0F0F0F0F}; req_wen = {4'h0, 4'hF};
    for (int j = 0; j < 4; j++) begin
      wait_ext(cyc);
      chk("fair_gap", cyc, (j == 0) ? 1 : 2);
      chk("fair_grant", grant_id, exp_g[j]);
      chk("fair_no_dual", ext_bus.ext_rd_req & ext_bus.ext_wr_req, 0);
      chk("fair_op", ext_bus.ext_wr_req, (exp_g[j] == 0));
      respond(exp_g[j] == 0, 1, 32'h00F00000 + j);
      chk("fair_pulse", {rsp_wval, rsp_rval}, (exp_g[j] == 0) ? 4'b0100 : 4'b0010);
      step();
      chk("fair_single_pulse", {rsp_rval, rsp_wval}, 0);
    end
    req_rd = '0; req_wr = '0;
    step();
    chk("fair_idle", busy, 0);

    // Requester 0 with read and write both high: write first, read on the next grant.
    req_rd = 2'b01; req_wr = 2'b01;
    req_addr = {32'h0, 32'hC0}; req_wdat = {32'h0, 32'h77778888}; req_wen = {4'h0, 4'hF};
    wait_ext(cyc);
    chk("rdwr_first_op", {grant_id, ext_bus.ext_wr_req, ext_bus.ext_rd_req}, 3'b010);
    respond(1'b1, 1, 32'h0);
    chk("rdwr_wval", {rsp_wval, rsp_rval}, 4'b0100);
    req_wr = 2'b00;
    step();
    wait_ext(cyc);
    chk("rdwr_second_gap", cyc, 2);
    chk("rdwr_second_op", {grant_id, ext_bus.ext_wr_req, ext_bus.ext_rd_req}, 3'b001);
    chk("rdwr_second_addr", ext_bus.ext_addr, 32'hC0);
    respond(1'b0, 1, 32'h5A5A1234);
    chk("rdwr_rval", {rsp_wval, rsp_rval}, 4'b0001);
    chk("rdwr_rdat", rsp_rdat, 32'h5A5A1234);
    req_rd = '0;
    step();
    step();

    // Reset while waiting on requester 1; late response must be ignored.
    req_rd = 2'b10; req_addr = {32'hD4, 32'hD0};
    wait_ext(cyc);
    chk("rst_pre_grant", {grant_id, ext_bus.ext_rd_req}, 2'b11);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_outputs_zero("rst_async");
    req_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    ext_bus.ext_rrsp_dat = 32'h99999999;
    ext_bus.ext_rrsp_val = 1'b1;
    step();
    ext_bus.ext_rrsp_val = 1'b0;
    chk("late_rsp_dropped", {rsp_rval, rsp_wval, busy}, 0);
    chk("late_rsp_rdat", rsp_rdat, 0);
    step();
    chk("late_rsp_dropped2", {rsp_rval, rsp_wval, busy}, 0);
    req_rd = 2'b11; req_addr = {32'hE4, 32'hE0};
    wait_ext(cyc);
    chk("post_rst_latency", cyc, 1);
    chk("post_rst_grant", grant_id, 0);
    chk("post_rst_addr", ext_bus.ext_addr, 32'hE0);
    respond(1'b0, 1, 32'h13579BDF);
    chk("post_rst_pulse", {rsp_wval, rsp_rval}, 4'b0001);
    chk("post_rst_rdat", rsp_rdat, 32'h13579BDF);
    req_rd = '0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ext_req_arb.md
Name: ext_req_arb

Overview:
Round-robin arbiter that shares one external memory request port between N requesters. The shared port uses the same rd_req/wr_req/wen/rsp_val convention as the axil_ext bridge. Typical use: instruction-fetch and data-side bridges in ultra_core sharing a single SRAM/peripheral port. One transaction is outstanding at a time. A per-grant timeout counter returns an error response if the target never answers.

Parameters:
N_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 32, data width
ADDR_WIDTH, 32, address width
STRB_WIDTH, DATA_WIDTH/8, write-enable width
TIMEOUT_CYC, 256, cycles from grant to forced error completion; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_rd  in  N_REQ  per-requester read request (level, held until own response)
req_wr  in  N_REQ  per-requester write request (level, held until own response)
req_addr  in  N_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i
req_wdat  in  N_REQ*DATA_WIDTH  packed write data
req_wen  in  N_REQ*STRB_WIDTH  packed byte enables
rsp_rdat  out  DATA_WIDTH  read data, shared by all requesters, valid with rsp_rval
rsp_rval  out  N_REQ  one-hot read-complete pulse
rsp_wval  out  N_REQ  one-hot write-complete pulse
rsp_err  out  1  set with a completion pulse when that completion was a timeout
ext_rd_req  out  1  downstream read request (level)
ext_wr_req  out  1  downstream write request (level)
ext_addr  out  ADDR_WIDTH  downstream address
ext_wr_dat  out  DATA_WIDTH  downstream write data
ext_wen  out  STRB_WIDTH  downstream byte enables
ext_rrsp_dat  in  DATA_WIDTH  downstream read data
ext_rrsp_val  in  1  downstream read done (1-cycle pulse)
ext_wrsp_val  in  1  downstream write done (1-cycle pulse)
grant_id  out  $clog2(N_REQ)  index of current or last grant (debug)
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: every output is 0, state is IDLE, RR pointer is 0, timeout counter is 0. Reset mid-transaction abandons the transaction. A downstream response arriving after reset is ignored.
- Register all outputs. Route no combinational path from any input to any output.
- States:
  - IDLE: if any req_rd|req_wr is high, select the first active requester at or after the RR pointer (wrapping modulo N_REQ). Latch its addr/wdat/wen/op into ext_* and grant_id. Assert ext_rd_req or ext_wr_req. Go to WAIT.
  - WAIT: hold ext_* stable and count cycles.
    - ext_rrsp_val (read grant) or ext_wrsp_val (write grant): deassert ext req, capture ext_rrsp_dat into rsp_rdat, go to DONE.
    - Counter reaching TIMEOUT_CYC-1 (when TIMEOUT_CYC ≠ 0): deassert ext req, set rsp_rdat=0, set rsp_err=1, go to DONE.
    - A response of the wrong type (e.g. wrsp on a read grant) is ignored.
  - DONE: pulse rsp_rval[g] or rsp_wval[g] for exactly one cycle, with rsp_err as set in WAIT. Set RR pointer = (g+1) mod N_REQ. Go to RELEASE.
  - RELEASE: one dead cycle so the requester can drop its request. Clear rsp_err. Go to IDLE. A request is never sampled in DONE or RELEASE.
- Latency: request in IDLE at cycle 0 → ext req at cycle 1. Downstream response at cycle k → requester pulse at cycle k+1 → earliest next ext req at cycle k+4.
- A requester with req_rd and req_wr both high is served as a write; the read stays pending.
- Downstream must not respond to a transaction that has timed out. A response arriving in IDLE/DONE/RELEASE is dropped.
- Request changes after grant have no effect; the values latched at grant are used.
- grant_id holds its last value in IDLE.
- rsp_rdat holds its value between completions.

Test Plan:
- Single read, N_REQ=2: req_rd[0]=1, addr 0x10000004; responder returns 0xA5A5_0001 three cycles after ext_rd_req → ext_addr=0x10000004; rsp_rval=2'b01 for 1 cycle at response+1 with rsp_rdat=0xA5A50001, rsp_err=0.
- Fairness: req_wr[0] and req_rd[1] held continuously, responder latency 1 → grants alternate 0,1,0,1; ext_wr_req and ext_rd_req are never high together; each grant gets exactly one completion pulse.
- Write fields: requester 1 writes data 0xDEADBEEF with wen 4'b0011 to 0x10000010 → ext_wr_dat/ext_wen/ext_addr match; rsp_wval=2'b10 one cycle after ext_wrsp_val.
- Timeout: TIMEOUT_CYC=8, responder silent → ext_rd_req falls after 8 cycles; rsp_rval pulses with rsp_err=1 and rsp_rdat=0; next pending requester is granted afterwards.
- Simultaneous rd+wr from requester 0 → write served first, then read on the next grant of requester 0.
- Reset asserted in WAIT → all outputs 0 immediately; a late ext_rrsp_val after reset produces no rsp pulse; the first grant after reset goes to requester 0.
